dma_chan_reg_file: RTL and testbench
====================================

// Module: dma_chan_reg_file
// PURPOSE
// - Parametrised 8237A-style programmable register file: per-channel base/current address and count, plus mode, command, mask, request and status.
// - Sits between the CPU I/O port and the DMA timing/priority engine.
// - Generalises to 1..4 channels and 16..32-bit address/count registers through a wrapping multi-byte pointer.
// - Adds auto-init reload and terminal-count (TC) handling fed from the engine's update port.
// PARAMETERS
// - NUM_CH  4   number of channels, 1..4
// - REG_W   16  address/count register width; multiple of 8, 16..32; NB = REG_W/8 bytes
// PORTS
// - clk          in   1            single clock, rising edge
// - reset_n      in   1            synchronous, active-low reset
// - cpu_cs       in   1            chip select, qualifies cpu_wr/cpu_rd
// - cpu_wr       in   1            one-cycle write strobe
// - cpu_rd       in   1            one-cycle read strobe
// - cpu_addr     in   4            register address; 0xxx = channel regs, 1xxx = control regs
// - cpu_wdata    in   8            write data
// - cpu_rdata    out  8            read data, registered
// - hw_dreq      in   NUM_CH       live DREQ levels, reported in status
// - upd_valid    in   1            engine update strobe
// - upd_ch       in   2            channel being updated
// - upd_addr     in   REG_W        next current address
// - upd_cnt      in   REG_W        next current count
// - upd_tc       in   1            TC reached on this update
// - cur_addr_o   out  NUM_CH*REG_W  current address registers, channel 0 in LSBs
// - cur_cnt_o    out  NUM_CH*REG_W  current count registers
// - mode_o       out  NUM_CH*6     mode[7:2] per channel
// - cmd_o        out  8            command register
// - mask_o       out  NUM_CH       channel mask bits
// - sw_req_o     out  NUM_CH       software request bits
// - tc_o         out  NUM_CH       TC status bits
// - tc_irq       out  1            TC interrupt (see CONFIGURATION)
// BEHAVIOUR
// - Reset / master clear (write to 1101), identical effect:
//   - cmd=0, modes=0, mask=all 1, sw_req=0, tc=0, byte pointer BP=0, cpu_rdata=0, tc_irq=0.
//   - Base/current address and count registers are all cleared to 0.
// - Accesses act only when cpu_cs=1. cpu_wr and cpu_rd together: the write is performed, the read is ignored, and cpu_rdata holds.
// - Channel regs at {0,ch[1:0],sel}, sel=0 address, sel=1 count:
//   - Write: byte BP of both base and current := cpu_wdata.
//   - Read: returns byte BP of current.
//   - Either access then advances BP := (BP+1) mod NB.
//   - Access to ch >= NUM_CH: no register change, reads 0, BP still advances.
// - Control regs:
//   - 1000 wr: cmd := wdata. 1000 rd: status = {4'(hw_dreq|sw_req), 4'(tc)}; tc cleared in the same edge.
//   - 1001 wr: sw_req[wdata[1:0]] := wdata[2].
//   - 1010 wr: mask[wdata[1:0]] := wdata[2].
//   - 1011 wr: mode[wdata[1:0]] := wdata[7:2].
//   - 1100 wr: BP := 0.
//   - 1110 wr: mask := 0.
//   - 1111 wr: mask := wdata[NUM_CH-1:0].
//   - Any selector ch >= NUM_CH: write ignored. Unmapped reads return 0.
// - Read latency: cpu_rdata valid the cycle after cpu_rd and held until the next read.
// - Update port (upd_valid=1, upd_ch < NUM_CH):
//   - Without TC: current addr/cnt := upd_addr/upd_cnt.
//   - With upd_tc=1: tc[ch] := 1 and sw_req[ch] := 0. Then:
//     - mode auto-init bit (mode[4]) = 1: current := base (upd values discarded).
//     - mode[4] = 0: current := upd values and mask[ch] := 1.
// - Collisions (same cycle):
//   - CPU write and update to the same channel's current regs: update wins on current, CPU write still lands in base. BP advances.
//   - Status-read clear and TC set on the same bit: set wins, bit stays 1.
//   - CPU mask/req write and TC on the same channel: TC effect wins.
// - Widths: channel selects are 2 bits; bits beyond NUM_CH in status are 0. No arithmetic is done in this block.
// CONFIGURATION
// - Macro DMA_TC_IRQ_EN.
// - Defined: tc_irq is registered and = |(tc & ~mask_prev), where mask_prev is the mask before any TC auto-mask in that cycle.
//   - Asserts 1 cycle after the TC bit sets; drops 1 cycle after the status read clears it.
// - Undefined: tc_irq is constant 0 and no extra logic is built.
// TESTING
// - Reset, then read status, cmd_o, mask_o -> 8'h00, 8'h00, all 1; BP=0.
// - REG_W=16: write ch1 addr bytes 34,12 -> cur_addr ch1 = 16'h1234; two reads return 34,12. Repeat with REG_W=24: three bytes, BP wraps after the 3rd.
// - Write 1100 mid-sequence after one byte -> next write lands in byte 0.
// - Mode ch2 = 8'h12 (auto-init), base cnt=5; upd ch2 cnt=0 tc=1 -> cur_cnt=5, tc[2]=1, mask[2] unchanged.
//   - Repeat with mode 8'h02 -> cur_cnt=0, mask[2]=1.
// - Upd tc on ch0 in the same cycle as a status read -> rdata bit0=0 and tc[0] stays 1. A second read returns bit0=1 and clears it.
// - DMA_TC_IRQ_EN defined: TC on unmasked ch3 -> tc_irq=1 next cycle, 0 one cycle after the status read. Undefined: tc_irq stays 0.

Source files
------------

// File: rtl/dma_chan_reg_file.sv
// 8237A-style DMA channel register file: per-channel base/current address and count,
// mode, command, mask, request and TC status. Optional TC interrupt under DMA_TC_IRQ_EN.
module dma_chan_reg_file #(
    parameter int NUM_CH = 4,
    parameter int REG_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cpu_cs,
    input  logic                    cpu_wr,
    input  logic                    cpu_rd,
    input  logic [3:0]              cpu_addr,
    input  logic [7:0]              cpu_wdata,
    output logic [7:0]              cpu_rdata,
    input  logic [NUM_CH-1:0]       hw_dreq,
    input  logic                    upd_valid,
    input  logic [1:0]              upd_ch,
    input  logic [REG_W-1:0]        upd_addr,
    input  logic [REG_W-1:0]        upd_cnt,
    input  logic                    upd_tc,
    output logic [NUM_CH*REG_W-1:0] cur_addr_o,
    output logic [NUM_CH*REG_W-1:0] cur_cnt_o,
    output logic [NUM_CH*6-1:0]     mode_o,
    output logic [7:0]              cmd_o,
    output logic [NUM_CH-1:0]       mask_o,
    output logic [NUM_CH-1:0]       sw_req_o,
    output logic [NUM_CH-1:0]       tc_o,
    output logic                    tc_irq
);
    localparam int NB = REG_W / 8;

    logic [REG_W-1:0]  base_addr [NUM_CH];
    logic [REG_W-1:0]  base_cnt  [NUM_CH];
    logic [REG_W-1:0]  cur_addr  [NUM_CH];
    logic [REG_W-1:0]  cur_cnt   [NUM_CH];
    logic [5:0]        mode      [NUM_CH];
    logic [7:0]        cmd;
    logic [NUM_CH-1:0] mask, sw_req, tc, tc_nxt;
    logic [1:0]        bp, bp_nxt;

    logic       do_wr, do_rd, ch_acc, stat_rd, master_clr, u_ok;
    logic       a_sel, a_ch_ok, w_ch_ok;
    logic [1:0] a_ch, w_ch;
    logic [3:0] req4, tc4;
    logic [7:0] ch_byte, rd_mux;

    assign do_wr      = cpu_cs & cpu_wr;
    assign do_rd      = cpu_cs & cpu_rd & ~cpu_wr;
    assign ch_acc     = (do_wr | do_rd) & ~cpu_addr[3];
    assign stat_rd    = do_rd & (cpu_addr == 4'h8);
    assign master_clr = do_wr & (cpu_addr == 4'hD);
    assign a_ch       = cpu_addr[2:1];
    assign a_sel      = cpu_addr[0];
    assign w_ch       = cpu_wdata[1:0];
    assign a_ch_ok    = int'(a_ch) < NUM_CH;
    assign w_ch_ok    = int'(w_ch) < NUM_CH;
    assign u_ok       = upd_valid & (int'(upd_ch) < NUM_CH);
    assign bp_nxt     = (bp == 2'(NB - 1)) ? 2'd0 : bp + 2'd1;

    always_comb begin
        req4    = '0;
        tc4     = '0;
        ch_byte = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            req4[c] = hw_dreq[c] | sw_req[c];
            tc4[c]  = tc[c];
        end
        if (a_ch_ok) begin
            for (int b = 0; b < NB; b++) begin
                if (bp == 2'(b))
                    ch_byte = a_sel ? cur_cnt[a_ch][b*8 +: 8] : cur_addr[a_ch][b*8 +: 8];
            end
        end
        rd_mux = '0;
        if (!cpu_addr[3])
            rd_mux = ch_byte;
        else if (cpu_addr == 4'h8)
            rd_mux = {req4, tc4};
    end

    // A TC set on the same edge as a status-read clear must survive.
    always_comb begin
        tc_nxt = tc;
        if (stat_rd)
            tc_nxt = '0;
        if (u_ok && upd_tc)
            tc_nxt[upd_ch] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n || master_clr) begin
            for (int c = 0; c < NUM_CH; c++) begin
                base_addr[c] <= '0;
                base_cnt[c]  <= '0;
                cur_addr[c]  <= '0;
                cur_cnt[c]   <= '0;
                mode[c]      <= '0;
            end
            cmd       <= '0;
            mask      <= '1;
            sw_req    <= '0;
            tc        <= '0;
            bp        <= '0;
            cpu_rdata <= '0;
        end else begin
            tc <= tc_nxt;
            if (ch_acc)
                bp <= bp_nxt;
            if (do_rd)
                cpu_rdata <= rd_mux;
            if (do_wr) begin
                if (!cpu_addr[3]) begin
                    if (a_ch_ok) begin
                        for (int b = 0; b < NB; b++) begin
                            if (bp == 2'(b)) begin
                                if (a_sel) begin
                                    base_cnt[a_ch][b*8 +: 8] <= cpu_wdata;
                                    cur_cnt[a_ch][b*8 +: 8]  <= cpu_wdata;
                                end else begin
                                    base_addr[a_ch][b*8 +: 8] <= cpu_wdata;
                                    cur_addr[a_ch][b*8 +: 8]  <= cpu_wdata;
                                end
                            end
                        end
                    end
                end else begin
                    case (cpu_addr[2:0])
                        3'd0: cmd <= cpu_wdata;
                        3'd1: if (w_ch_ok) sw_req[w_ch] <= cpu_wdata[2];
                        3'd2: if (w_ch_ok) mask[w_ch] <= cpu_wdata[2];
                        3'd3: if (w_ch_ok) mode[w_ch] <= cpu_wdata[7:2];
                        3'd4: bp <= '0;
                        3'd6: mask <= '0;
                        3'd7: mask <= cpu_wdata[NUM_CH-1:0];
                        default: ;
                    endcase
                end
            end
            // Engine update is applied last so it overrides same-cycle CPU writes.
            if (u_ok) begin
                if (upd_tc && mode[upd_ch][2]) begin
                    cur_addr[upd_ch] <= base_addr[upd_ch];
                    cur_cnt[upd_ch]  <= base_cnt[upd_ch];
                end else begin
                    cur_addr[upd_ch] <= upd_addr;
                    cur_cnt[upd_ch]  <= upd_cnt;
                end
                if (upd_tc) begin
                    sw_req[upd_ch] <= 1'b0;
                    if (!mode[upd_ch][2])
                        mask[upd_ch] <= 1'b1;
                end
            end
        end
    end

`ifdef DMA_TC_IRQ_EN
    // mask here is still the pre-auto-mask value for this edge.
    always_ff @(posedge clk) begin
        if (!reset_n || master_clr)
            tc_irq <= 1'b0;
        else
            tc_irq <= |(tc_nxt & ~mask);
    end
`else
    assign tc_irq = 1'b0;
`endif

    always_comb begin
        cur_addr_o = '0;
        cur_cnt_o  = '0;
        mode_o     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            cur_addr_o[c*REG_W +: REG_W] = cur_addr[c];
            cur_cnt_o[c*REG_W +: REG_W]  = cur_cnt[c];
            mode_o[c*6 +: 6]             = mode[c];
        end
    end

    assign cmd_o    = cmd;
    assign mask_o   = mask;
    assign sw_req_o = sw_req;
    assign tc_o     = tc;
endmodule

// File: tb/tb_dma_chan_reg_file.sv
// Scoreboard bench for dma_chan_reg_file: a 16-bit and a 24-bit instance, read data
// checked against a queue of expected bytes pushed when each read is issued.
module tb_dma_chan_reg_file;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        cs16, cs24, cpu_wr, cpu_rd;
    logic [3:0]  cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  rdata16, rdata24;
    logic [3:0]  hw_dreq;
    logic        upd_valid, upd_tc;
    logic [1:0]  upd_ch;
    logic [23:0] upd_addr, upd_cnt;

    logic [63:0] cur_addr16, cur_cnt16;
    logic [95:0] cur_addr24, cur_cnt24;
    logic [23:0] mode16, mode24;
    logic [7:0]  cmd16, cmd24;
    logic [3:0]  mask16, mask24, req16, req24, tc16, tc24;
    logic        irq16, irq24;

    int checks = 0;
    int failures = 0;
    logic [7:0] q16[$];
    logic [7:0] q24[$];
    logic rd16_d = 1'b0;
    logic rd24_d = 1'b0;
    logic exp_irq;

    always #5 clk = ~clk;

    dma_chan_reg_file #(.NUM_CH(4), .REG_W(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .cpu_cs(cs16), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(rdata16), .hw_dreq(hw_dreq),
        .upd_valid(upd_valid), .upd_ch(upd_ch), .upd_addr(upd_addr[15:0]),
        .upd_cnt(upd_cnt[15:0]), .upd_tc(upd_tc), .cur_addr_o(cur_addr16),
        .cur_cnt_o(cur_cnt16), .mode_o(mode16), .cmd_o(cmd16), .mask_o(mask16),
        .sw_req_o(req16), .tc_o(tc16), .tc_irq(irq16));

    dma_chan_reg_file #(.NUM_CH(4), .REG_W(24)) dut24 (
        .clk(clk), .reset_n(reset_n), .cpu_cs(cs24), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(rdata24), .hw_dreq(hw_dreq),
        .upd_valid(upd_valid), .upd_ch(upd_ch), .upd_addr(upd_addr),
        .upd_cnt(upd_cnt), .upd_tc(upd_tc), .cur_addr_o(cur_addr24),
        .cur_cnt_o(cur_cnt24), .mode_o(mode24), .cmd_o(cmd24), .mask_o(mask24),
        .sw_req_o(req24), .tc_o(tc24), .tc_irq(irq24));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        rd16_d <= cs16 && cpu_rd && !cpu_wr;
        rd24_d <= cs24 && cpu_rd && !cpu_wr;
    end

    always @(negedge clk) begin
        if (rd16_d) begin
            if (q16.size() == 0) check("rd16_unexpected", 64'(rdata16), 64'hx);
            else check("rdata16", 64'(rdata16), 64'(q16.pop_front()));
        end
        if (rd24_d) begin
            if (q24.size() == 0) check("rd24_unexpected", 64'(rdata24), 64'hx);
            else check("rdata24", 64'(rdata24), 64'(q24.pop_front()));
        end
    end

    task automatic cyc(input bit s24, input bit w, input bit r, input logic [3:0] a,
                       input logic [7:0] d, input bit uv, input logic [1:0] uc,
                       input logic [23:0] ua, input logic [23:0] un, input bit ut,
                       input logic [7:0] exp_rd);
        @(negedge clk);
        if (r && !w) begin
            if (s24) q24.push_back(exp_rd);
            else     q16.push_back(exp_rd);
        end
        cs16 = (w || r) && !s24;
        cs24 = (w || r) && s24;
        cpu_wr = w; cpu_rd = r; cpu_addr = a; cpu_wdata = d;
        upd_valid = uv; upd_ch = uc; upd_addr = ua; upd_cnt = un; upd_tc = ut;
        @(negedge clk);
        cs16 = 0; cs24 = 0; cpu_wr = 0; cpu_rd = 0; upd_valid = 0; upd_tc = 0;
    endtask

    task automatic wr16(input logic [3:0] a, input logic [7:0] d);
        cyc(0, 1, 0, a, d, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic wr24(input logic [3:0] a, input logic [7:0] d);
        cyc(1, 1, 0, a, d, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic rd16(input logic [3:0] a, input logic [7:0] e);
        cyc(0, 0, 1, a, 0, 0, 0, 0, 0, 0, e);
    endtask
    task automatic rd24(input logic [3:0] a, input logic [7:0] e);
        cyc(1, 0, 1, a, 0, 0, 0, 0, 0, 0, e);
    endtask
    task automatic upd(input logic [1:0] c, input logic [23:0] ua, input logic [23:0] un, input bit t);
        cyc(0, 0, 0, 0, 0, 1, c, ua, un, t, 0);
    endtask

    initial begin
`ifdef DMA_TC_IRQ_EN
        exp_irq = 1'b1;
`else
        exp_irq = 1'b0;
`endif
        reset_n = 0; cs16 = 0; cs24 = 0; cpu_wr = 0; cpu_rd = 0; cpu_addr = 0; cpu_wdata = 0;
        hw_dreq = 0; upd_valid = 0; upd_ch = 0; upd_addr = 0; upd_cnt = 0; upd_tc = 0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1;

        check("rst_cmd", 64'(cmd16), 64'h00);
        check("rst_mask", 64'(mask16), 64'hF);
        check("rst_tc", 64'(tc16), 64'h0);
        check("rst_rdata", 64'(rdata16), 64'h00);
        check("rst_irq", 64'(irq16), 64'h0);
        rd16(4'h8, 8'h00);
        hw_dreq = 4'b0101;
        rd16(4'h8, 8'h50);
        hw_dreq = 4'b0000;

        // 16-bit multi-byte address, BP wraps after two bytes
        wr16(4'h2, 8'h34);
        wr16(4'h2, 8'h12);
        check("ch1_addr16", 64'(cur_addr16[31:16]), 64'h1234);
        rd16(4'h2, 8'h34);
        rd16(4'h2, 8'h12);

        // 24-bit: three bytes, fourth write wraps to byte 0, then BP reset
        wr24(4'h2, 8'h56);
        wr24(4'h2, 8'h34);
        wr24(4'h2, 8'h12);
        check("ch1_addr24", 64'(cur_addr24[47:24]), 64'h123456);
        wr24(4'h2, 8'hAA);
        check("ch1_addr24_wrap", 64'(cur_addr24[47:24]), 64'h1234AA);
        wr24(4'hC, 8'h00);
        rd24(4'h2, 8'hAA);
        rd24(4'h2, 8'h34);
        rd24(4'h2, 8'h12);

        // BP clear mid-sequence
        wr16(4'h1, 8'h77);
        wr16(4'hC, 8'h00);
        wr16(4'h1, 8'h99);
        check("bp_clear", 64'(cur_cnt16[15:0]), 64'h0099);
        wr16(4'hC, 8'h00);

        wr16(4'h8, 8'hA5);
        check("cmd", 64'(cmd16), 64'hA5);

        // auto-init TC on ch2
        wr16(4'hB, 8'h12);
        check("mode2", 64'(mode16[17:12]), 64'h04);
        wr16(4'h5, 8'h05);
        wr16(4'h5, 8'h00);
        wr16(4'hA, 8'h02);
        check("unmask2", 64'(mask16), 64'hB);
        wr16(4'h9, 8'h06);
        check("swreq2", 64'(req16), 64'h4);
        upd(2, 24'h002222, 24'h000000, 1);
        check("ai_cnt", 64'(cur_cnt16[47:32]), 64'h0005);
        check("ai_addr", 64'(cur_addr16[47:32]), 64'h0000);
        check("ai_tc", 64'(tc16), 64'h4);
        check("ai_mask", 64'(mask16), 64'hB);
        check("ai_swreq", 64'(req16), 64'h0);
        check("ai_irq", 64'(irq16), 64'(exp_irq));
        rd16(4'h8, 8'h04);
        check("ai_tc_clr", 64'(tc16), 64'h0);
        check("ai_irq_clr", 64'(irq16), 64'h0);

        // non-auto-init TC on ch2
        wr16(4'hB, 8'h02);
        upd(2, 24'h003333, 24'h000000, 1);
        check("na_cnt", 64'(cur_cnt16[47:32]), 64'h0000);
        check("na_addr", 64'(cur_addr16[47:32]), 64'h3333);
        check("na_mask", 64'(mask16), 64'hF);
        check("na_irq", 64'(irq16), 64'(exp_irq));
        rd16(4'h8, 8'h04);

        // plain update
        upd(1, 24'h00ABCD, 24'h000042, 0);
        check("upd_addr", 64'(cur_addr16[31:16]), 64'hABCD);
        check("upd_cnt", 64'(cur_cnt16[31:16]), 64'h0042);
        check("upd_tc", 64'(tc16), 64'h0);

        // TC interrupt on unmasked auto-init ch3
        wr16(4'hA, 8'h03);
        wr16(4'hB, 8'h13);
        check("irq_pre", 64'(irq16), 64'h0);
        upd(3, 24'h0, 24'h0, 1);
        check("irq3", 64'(irq16), 64'(exp_irq));
        check("irq3_mask", 64'(mask16), 64'h7);
        rd16(4'h8, 8'h08);
        check("irq3_clr", 64'(irq16), 64'h0);

        // status-read clear colliding with TC set on ch0
        cyc(0, 0, 1, 4'h8, 0, 1, 0, 24'h0, 24'h0, 1, 8'h00);
        check("coll_tc", 64'(tc16), 64'h1);
        rd16(4'h8, 8'h01);
        check("coll_tc_clr", 64'(tc16), 64'h0);

        // master clear
        wr16(4'hD, 8'h00);
        check("mc_cmd", 64'(cmd16), 64'h00);
        check("mc_mask", 64'(mask16), 64'hF);
        check("mc_addr", 64'(cur_addr16), 64'h0);
        check("mc_mode", 64'(mode16), 64'h0);
        check("mc_rdata", 64'(rdata16), 64'h00);

        // simultaneous write+read: write lands, rdata holds
        hw_dreq = 4'b0011;
        rd16(4'h8, 8'h30);
        hw_dreq = 4'b0000;
        cyc(0, 1, 1, 4'h8, 8'h5A, 0, 0, 0, 0, 0, 0);
        check("wr_rd_cmd", 64'(cmd16), 64'h5A);
        check("wr_rd_hold", 64'(rdata16), 64'h30);
        rd16(4'h9, 8'h00);

        repeat (2) @(negedge clk);
        check("q16_drained", 64'(q16.size()), 64'h0);
        check("q24_drained", 64'(q24.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
